// File: rtl/cnt_sched_if.sv
// rtl/cnt_sched_if.sv - request/response/counter signal bundle for cnt_sched
interface cnt_sched_if;
    logic [1:0]      req_valid;
    logic [1:0][3:0] req_start;
    logic [1:0]      req_down;
    logic [1:0][3:0] req_len;
    logic [1:0]      req_ready;
    logic            rsp_valid;
    logic            rsp_id;
    logic [3:0]      rsp_count;
    logic            rsp_wrap;
    logic            rsp_err;
    logic            busy;
    logic            cnt_load_en;
    logic [3:0]      cnt_load;
    logic            cnt_down;
    logic [3:0]      cnt_count;

    modport master (
        output req_valid, req_start, req_down, req_len, cnt_count,
        input  req_ready, rsp_valid, rsp_id, rsp_count, rsp_wrap, rsp_err,
               busy, cnt_load_en, cnt_load, cnt_down
    );

    modport slave (
        input  req_valid, req_start, req_down, req_len, cnt_count,
        output req_ready, rsp_valid, rsp_id, rsp_count, rsp_wrap, rsp_err,
               busy, cnt_load_en, cnt_load, cnt_down
    );
endinterface

// File: rtl/cnt_sched.sv
// rtl/cnt_sched.sv - two-requester round-robin scheduler driving an external up/down counter
module cnt_sched (
    input  logic         clk,
    input  logic         rstn,
    cnt_sched_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic [3:0] park_q, park_d;
    logic [3:0] rem_q, rem_d;
    logic       id_q, id_d;
    logic       down_q, down_d;
    logic [3:0] start_q, start_d;
    logic [3:0] len_q, len_d;
    logic [3:0] exp_q, exp_d;
    logic       wrap_q, wrap_d;
    logic       rsp_id_q, rsp_id_d;
    logic [3:0] rsp_count_q, rsp_count_d;
    logic       rsp_wrap_q, rsp_wrap_d;
    logic       rsp_err_q, rsp_err_d;

    logic [1:0] grant;
    logic       sel;
    logic [4:0] sum5, diff5;
    logic [1:0] ready_c;
    logic       rsp_valid_c, busy_c, load_en_c, down_c;
    logic [3:0] load_c;

    // Both requesting: pointer wins; otherwise the lone requester wins.
    always_comb begin
        grant = bus.req_valid;
        if (bus.req_valid == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
        sel   = grant[1];
        sum5  = {1'b0, bus.req_start[sel]} + {1'b0, bus.req_len[sel]};
        diff5 = {1'b0, bus.req_start[sel]} - {1'b0, bus.req_len[sel]};
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        park_d      = park_q;
        rem_d       = rem_q;
        id_d        = id_q;
        down_d      = down_q;
        start_d     = start_q;
        len_d       = len_q;
        exp_d       = exp_q;
        wrap_d      = wrap_q;
        rsp_id_d    = rsp_id_q;
        rsp_count_d = rsp_count_q;
        rsp_wrap_d  = rsp_wrap_q;
        rsp_err_d   = rsp_err_q;
        ready_c     = 2'b00;
        rsp_valid_c = 1'b0;
        busy_c      = 1'b0;
        load_en_c   = 1'b0;
        load_c      = 4'd0;
        down_c      = 1'b0;
        if (rstn) begin
            case (state_q)
                IDLE: begin
                    load_en_c = 1'b1;
                    load_c    = park_q;
                    ready_c   = grant;
                    if (grant != 2'b00) begin
                        id_d    = sel;
                        start_d = bus.req_start[sel];
                        down_d  = bus.req_down[sel];
                        len_d   = bus.req_len[sel];
                        // Bit 4 is the carry (up) or borrow (down) across the 4-bit boundary.
                        exp_d   = bus.req_down[sel] ? diff5[3:0] : sum5[3:0];
                        wrap_d  = bus.req_down[sel] ? diff5[4] : sum5[4];
                        ptr_d   = ~sel;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    busy_c    = 1'b1;
                    load_en_c = 1'b1;
                    load_c    = start_q;
                    down_c    = down_q;
                    rem_d     = len_q;
                    state_d   = (len_q != 4'd0) ? RUN : DONE;
                end
                RUN: begin
                    busy_c = 1'b1;
                    down_c = down_q;
                    rem_d  = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    busy_c      = 1'b1;
                    rsp_valid_c = 1'b1;
                    load_en_c   = 1'b1;
                    load_c      = bus.cnt_count;
                    park_d      = bus.cnt_count;
                    rsp_id_d    = id_q;
                    rsp_count_d = bus.cnt_count;
                    rsp_wrap_d  = wrap_q;
                    rsp_err_d   = (bus.cnt_count != exp_q);
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            park_q      <= 4'd0;
            rem_q       <= 4'd0;
            id_q        <= 1'b0;
            down_q      <= 1'b0;
            start_q     <= 4'd0;
            len_q       <= 4'd0;
            exp_q       <= 4'd0;
            wrap_q      <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_count_q <= 4'd0;
            rsp_wrap_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            park_q      <= park_d;
            rem_q       <= rem_d;
            id_q        <= id_d;
            down_q      <= down_d;
            start_q     <= start_d;
            len_q       <= len_d;
            exp_q       <= exp_d;
            wrap_q      <= wrap_d;
            rsp_id_q    <= rsp_id_d;
            rsp_count_q <= rsp_count_d;
            rsp_wrap_q  <= rsp_wrap_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Response fields are live during DONE and hold the last completion otherwise.
    assign bus.req_ready   = ready_c;
    assign bus.rsp_valid   = rsp_valid_c;
    assign bus.rsp_id      = rsp_valid_c ? id_q : rsp_id_q;
    assign bus.rsp_count   = rsp_valid_c ? bus.cnt_count : rsp_count_q;
    assign bus.rsp_wrap    = rsp_valid_c ? wrap_q : rsp_wrap_q;
    assign bus.rsp_err     = rsp_valid_c ? (bus.cnt_count != exp_q) : rsp_err_q;
    assign bus.busy        = busy_c;
    assign bus.cnt_load_en = load_en_c;
    assign bus.cnt_load    = load_c;
    assign bus.cnt_down    = down_c;
endmodule
